// File: rtl/cpu_pkg.sv
// Shared constants and types for the square-root compute block.
package cpu_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned OPER_W    = 2 * DATA_W;
  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned BIT_W     = 3;

  localparam logic [ADDR_W-1:0] OPERAND_HI_ADDR = ADDR_W'(16);
  localparam logic [ADDR_W-1:0] OPERAND_LO_ADDR = ADDR_W'(17);
  localparam logic [ADDR_W-1:0] RESULT_ADDR     = ADDR_W'(18);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: two combinational read ports, one synchronous write port.
module data_mem
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] din
);

  logic [DATA_W-1:0] Core [MEM_DEPTH];

  assign rd_data_a = Core[rd_addr_a];
  assign rd_data_b = Core[rd_addr_b];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      Core[addr] <= din;
    end
  end

endmodule

// File: rtl/cpu.sv
// Sequencer computing floor(sqrt) of a 16-bit operand held in data memory,
// one result bit per cycle by trial squaring.
module cpu
  import cpu_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);

  state_t              state;
  logic                start_q;
  logic [DATA_W-1:0]   root;
  logic [OPER_W-1:0]   x;
  logic [BIT_W-1:0]    bit_idx;

  logic                launch_c;
  logic [DATA_W-1:0]   cand_c;
  logic [OPER_W-1:0]   cand_sq_c;
  logic [DATA_W-1:0]   op_hi_c;
  logic [DATA_W-1:0]   op_lo_c;
  logic                store_we_c;

  assign launch_c   = start_q & ~Start;
  assign cand_c     = root | (DATA_W'(1) << bit_idx);
  assign cand_sq_c  = OPER_W'(cand_c) * OPER_W'(cand_c);
  assign store_we_c = (state == STORE);

  data_mem DM1 (
    .clk       (Clk),
    .rd_addr_a (OPERAND_HI_ADDR),
    .rd_data_a (op_hi_c),
    .rd_addr_b (OPERAND_LO_ADDR),
    .rd_data_b (op_lo_c),
    .addr      (RESULT_ADDR),
    .we        (store_we_c),
    .din       (root)
  );

  // Start high anywhere but DONE aborts; in DONE it acknowledges the result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      Ack     <= 1'b0;
      root    <= '0;
      x       <= '0;
      bit_idx <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= Start;
      if (Start && state != DONE) begin
        state <= IDLE;
        Ack   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            Ack <= 1'b0;
            if (launch_c) begin
              state <= LOAD;
            end
          end
          LOAD: begin
            x       <= {op_hi_c, op_lo_c};
            root    <= '0;
            bit_idx <= BIT_W'(DATA_W - 1);
            state   <= ITER;
          end
          ITER: begin
            if (cand_sq_c <= x) begin
              root <= cand_c;
            end
            if (bit_idx == '0) begin
              state <= STORE;
            end else begin
              bit_idx <= bit_idx - BIT_W'(1);
            end
          end
          STORE: begin
            Ack   <= 1'b1;
            state <= DONE;
          end
          DONE: begin
            if (Start) begin
              Ack   <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            Ack   <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Randomized self-checking bench for cpu against an integer square-root model.
module tb_cpu;

  logic Clk = 1'b0;
  logic Reset;
  logic Start;
  logic Ack;

  int checks = 0;
  int errors = 0;

  logic [7:0] snap [256];

  cpu dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic load(input logic [15:0] v);
    dut.DM1.Core[16] = v[15:8];
    dut.DM1.Core[17] = v[7:0];
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (Ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run(input logic [15:0] v, input string tag);
    bit ok;
    @(negedge Clk);
    Start = 1'b1;
    load(v);
    @(negedge Clk);
    Start = 1'b0;
    wait_ack(ok);
    check({tag, " ack"}, 32'(ok), 32'd1);
    check({tag, " result"}, 32'(dut.DM1.Core[18]), 32'(isqrt(int'(v))));
    repeat (2) @(posedge Clk);
    #1;
    check({tag, " ack_hold"}, 32'(Ack), 32'd1);
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    check({tag, " ack_fall"}, 32'(Ack), 32'd0);
  endtask

  initial begin
    int diffs;
    logic [15:0] v;
    int n;

    Reset = 1'b1;
    Start = 1'b1;
    #10;
    check("reset ack", 32'(Ack), 32'd0);
    Reset = 1'b0;

    run(16'd190,   "op190");
    run(16'd0,     "op0");
    run(16'hFFFF,  "op65535");
    run(16'd144,   "op144");
    run(16'd143,   "op143");

    // Only the result byte may change.
    @(negedge Clk);
    load(16'd256);
    dut.DM1.Core[18] = 8'hAA;
    for (int i = 0; i < 256; i++) snap[i] = dut.DM1.Core[i];
    run(16'd256, "op256");
    diffs = 0;
    for (int i = 0; i < 256; i++) begin
      if (i != 18 && dut.DM1.Core[i] !== snap[i]) diffs++;
    end
    check("untouched", 32'(diffs), 32'd0);

    // Reset three cycles after launch.
    @(negedge Clk);
    Start = 1'b1;
    load(16'd50000);
    dut.DM1.Core[18] = 8'hAA;
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("midrun reset ack", 32'(Ack), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (15) @(posedge Clk);
    #1;
    check("no autolaunch ack", 32'(Ack), 32'd0);
    check("midrun reset keep", 32'(dut.DM1.Core[18]), 32'hAA);
    run(16'd50000, "after_reset");

    // Start raised mid-computation aborts without writing.
    @(negedge Clk);
    Start = 1'b1;
    load(16'd40000);
    dut.DM1.Core[18] = 8'h55;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Start = 1'b1;
    repeat (15) @(posedge Clk);
    #1;
    check("abort ack", 32'(Ack), 32'd0);
    check("abort keep", 32'(dut.DM1.Core[18]), 32'h55);
    run(16'd40000, "after_abort");

    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 2))
        0: v = 16'($urandom_range(0, 65535));
        1: begin n = $urandom_range(0, 255); v = 16'(n * n); end
        default: begin n = $urandom_range(1, 255); v = 16'(n * n - 1); end
      endcase
      run(v, $sformatf("rand%0d_x%0d", k, v));
    end

    run(16'd10000, "op10000");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
